// File: rtl/imem_byte_loader_if.sv
// Byte-stream and IMEM write-port bundle for the instruction memory loader.
// A byte moves only on a cycle where s_valid and s_ready are both high. s_ready never depends on s_valid.
interface imem_byte_loader_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] length;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic             word_valid;
  logic [31:0]      word_addr;
  logic [31:0]      word_data;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       checksum;
  logic [LEN_W-1:0] byte_count;

  modport master (
    output start, base_addr, length, s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata, word_valid, word_addr, word_data,
    input  cpu_hold, busy, done, err, checksum, byte_count
  );

  modport slave (
    input  start, base_addr, length, s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata, word_valid, word_addr, word_data,
    output cpu_hold, busy, done, err, checksum, byte_count
  );
endinterface

// File: rtl/imem_byte_loader.sv
// Streams bytes into a little-endian IMEM at base_addr+offset. It also emits assembled words
// for trace and keeps a running 8-bit checksum. The core is held off while the load runs.
module imem_byte_loader #(
  parameter int IMEM_SIZE = 1024,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  imem_byte_loader_if.slave bus,
  output logic [1:0]        o_dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_base;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [7:0]       r_sum;
  logic [31:0]      r_buf;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [7:0]       r_mem_wdata;
  logic             r_word_valid;
  logic [31:0]      r_word_addr;
  logic [31:0]      r_word_data;
  logic             r_done;
  logic             r_err;

  logic             w_ready;
  logic             w_xfer;
  logic [32:0]      w_end_addr;
  logic             w_bad_start;
  logic [1:0]       w_lane;
  logic [LEN_W-1:0] w_next_count;
  logic             w_last;
  logic             w_word_end;
  logic [31:0]      w_byte_addr;
  logic [31:0]      w_word_base;
  logic [31:0]      w_merged;

  assign w_ready      = (r_state == S_LOAD);
  assign w_xfer       = bus.s_valid & w_ready;
  // 33-bit end address so a base near 4 GiB cannot wrap past the size check.
  assign w_end_addr   = {1'b0, bus.base_addr} + 33'(bus.length);
  assign w_bad_start  = (bus.base_addr[1:0] != 2'b00) || (w_end_addr > 33'(IMEM_SIZE));
  assign w_lane       = r_count[1:0];
  assign w_next_count = r_count + LEN_W'(1);
  assign w_last       = (w_next_count == r_len);
  assign w_word_end   = (w_lane == 2'd3) || w_last;
  assign w_byte_addr  = r_base + 32'(r_count);
  assign w_word_base  = {w_byte_addr[31:2], 2'b00};

  always_comb begin
    w_merged = r_buf;
    w_merged[{w_lane, 3'b000} +: 8] = bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_len        <= '0;
      r_count      <= '0;
      r_sum        <= '0;
      r_buf        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_word_valid <= 1'b0;
      r_word_addr  <= '0;
      r_word_data  <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_word_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_bad_start) begin
              r_err <= 1'b1;
            end else begin
              r_base  <= bus.base_addr;
              r_len   <= bus.length;
              r_count <= '0;
              r_sum   <= '0;
              r_buf   <= '0;
              if (bus.length == '0) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_byte_addr;
            r_mem_wdata <= bus.s_data;
            r_count     <= w_next_count;
            r_sum       <= r_sum + bus.s_data;
            // A short tail is emitted with the last byte's write, so it is visible in FLUSH.
            if (w_word_end) begin
              r_word_valid <= 1'b1;
              r_word_addr  <= w_word_base;
              r_word_data  <= w_merged;
              r_buf        <= '0;
            end else begin
              r_buf <= w_merged;
            end
            if (w_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready    = w_ready;
  assign bus.cpu_hold   = (r_state == S_LOAD) || (r_state == S_FLUSH);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.word_valid = r_word_valid;
  assign bus.word_addr  = r_word_addr;
  assign bus.word_data  = r_word_data;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.checksum   = r_sum;
  assign bus.byte_count = r_count;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_imem_byte_loader.sv
// Bench for imem_byte_loader: queue-based reference model of writes, words and completion,
// driven by directed and randomized byte streams.
module tb_imem_byte_loader;
  localparam int IMEM_SIZE = 1024;
  localparam int LEN_W     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  imem_byte_loader_if #(.LEN_W(LEN_W)) bus ();

  imem_byte_loader #(.IMEM_SIZE(IMEM_SIZE), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [39:0] exp_wr_q[$];
  logic [63:0] exp_word_q[$];
  logic [23:0] exp_done_q[$];
  logic [63:0] obs_words[$];
  logic [7:0]  bytes_q[$];
  int          obs_wr_cnt = 0;
  int          n_err_exp  = 0;
  int          n_err_obs  = 0;
  logic [7:0]  last_sum   = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, required no event", name, act);
  endtask

  // Compare process: every output event is matched against the model's queues.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      obs_wr_cnt++;
      if (exp_wr_q.size() == 0) unexpected("mem_write", {bus.mem_addr, bus.mem_wdata});
      else check("mem_write", {bus.mem_addr, bus.mem_wdata}, exp_wr_q.pop_front());
    end
    if (bus.word_valid) begin
      obs_words.push_back({bus.word_addr, bus.word_data});
      if (exp_word_q.size() == 0) unexpected("word", {bus.word_addr, bus.word_data});
      else check("word", {bus.word_addr, bus.word_data}, exp_word_q.pop_front());
    end
    if (bus.done) begin
      last_sum = bus.checksum;
      check("done_state", {bus.busy, bus.cpu_hold}, 2'b10);
      if (exp_done_q.size() == 0) unexpected("done", {bus.byte_count, bus.checksum});
      else check("done_count_sum", {bus.byte_count, bus.checksum}, exp_done_q.pop_front());
    end
    if (bus.err) n_err_obs++;
    if (bus.s_ready) check("hold_in_load", {bus.cpu_hold, bus.busy}, 2'b11);
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {bus.s_ready, bus.cpu_hold, bus.busy, bus.mem_we, bus.word_valid,
                            bus.done, bus.err, dbg_state}, 64'h0);
    check({name, "_data"}, {bus.checksum, bus.byte_count, bus.mem_wdata}, 64'h0);
    check({name, "_addr"}, {bus.mem_addr, bus.word_addr}, 64'h0);
    check({name, "_wdata"}, bus.word_data, 64'h0);
  endtask

  // Model: a start is accepted or rejected from address arithmetic alone; an accepted
  // load yields one write per byte, one word per 4-byte group (zero-padded) and one done.
  task automatic do_start(input logic [31:0] base, input int len, output bit acc);
    longint      end_a;
    logic [7:0]  sum;
    logic [31:0] w;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = LEN_W'(len);
    end_a = longint'(base) + longint'(len);
    acc = (base[1:0] == 2'b00) && (end_a <= longint'(IMEM_SIZE));
    if (!acc) begin
      n_err_exp++;
    end else begin
      sum = 8'h00;
      for (int i = 0; i < len; i++) begin
        exp_wr_q.push_back({base + 32'(i), bytes_q[i]});
        sum += bytes_q[i];
      end
      for (int k = 0; k < (len + 3) / 4; k++) begin
        w = 32'h0;
        for (int l = 0; l < 4; l++)
          if (4 * k + l < len) w[8 * l +: 8] = bytes_q[4 * k + l];
        exp_word_q.push_back({base + 32'(4 * k), w});
      end
      exp_done_q.push_back({16'(len), sum});
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode < 0: s_valid toggles 1/0; otherwise percent chance of s_valid per cycle.
  task automatic send_bytes(input int stop_after, input int start_at, input int mode);
    int i   = 0;
    int cyc = 0;
    while (i < bytes_q.size() && i != stop_after && cyc < 4000) begin
      @(negedge clk);
      if (mode < 0) bus.s_valid = (cyc % 2 == 0);
      else          bus.s_valid = ($urandom_range(1, 100) <= mode);
      bus.s_data = bus.s_valid ? bytes_q[i] : 8'($urandom_range(0, 255));
      bus.start  = (start_at >= 0) && (i == start_at);
      if (bus.start) begin
        bus.base_addr = 32'h0;
        bus.length    = LEN_W'(3);
      end
      if (bus.s_valid && bus.s_ready) i++;
      cyc++;
    end
    if (cyc >= 4000) check("send_progress", i, bytes_q.size());
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
  endtask

  task automatic end_test(input string name);
    int c = 0;
    while (bus.busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    check({name, "_idle"}, bus.busy, 0);
    repeat (2) @(negedge clk);
    check({name, "_writes_left"}, exp_wr_q.size(), 0);
    check({name, "_words_left"}, exp_word_q.size(), 0);
    check({name, "_done_left"}, exp_done_q.size(), 0);
    check({name, "_err_count"}, n_err_obs, n_err_exp);
  endtask

  task automatic run_load(input string name, input logic [31:0] base, input int len,
                          input int mode, input int start_at, input bit preset);
    bit acc;
    if (!preset) begin
      bytes_q.delete();
      for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    end
    do_start(base, len, acc);
    if (!acc) check({name, "_err_pulse"}, {bus.err, bus.busy}, 2'b10);
    if (acc && len > 0) send_bytes(-1, start_at, mode);
    end_test(name);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bus.start     = 1'b0;
    bus.base_addr = 32'h0;
    bus.length    = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: two full words back-to-back
    obs_words.delete();
    obs_wr_cnt = 0;
    bytes_q = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    run_load("t1", 32'h0, 8, 100, -1, 1'b1);
    check("t1_nwords", obs_words.size(), 2);
    check("t1_word0", obs_words[0], {32'h0, 32'h00400093});
    check("t1_word1", obs_words[1], {32'h4, 32'h00100113});
    check("t1_sum", last_sum, 8'hF7);
    check("t1_writes", obs_wr_cnt, 8);

    // 2: s_valid toggling
    obs_words.delete();
    obs_wr_cnt = 0;
    bytes_q = '{8'h6f, 8'h04, 8'h00, 8'h01};
    run_load("t2", 32'h18, 4, -1, -1, 1'b1);
    check("t2_nwords", obs_words.size(), 1);
    check("t2_word0", obs_words[0], {32'h18, 32'h0100046F});
    check("t2_writes", obs_wr_cnt, 4);

    // 3: partial tail word
    obs_words.delete();
    obs_wr_cnt = 0;
    run_load("t3", 32'h20, 6, 100, -1, 1'b0);
    check("t3_nwords", obs_words.size(), 2);
    check("t3_tail_addr", obs_words[1][63:32], 32'h24);
    check("t3_tail_upper", obs_words[1][31:16], 16'h0);
    check("t3_writes", obs_wr_cnt, 6);

    // 4: rejected starts, zero length, exact-fit boundary
    obs_wr_cnt = 0;
    run_load("t4a", 32'h3FE, 4, 100, -1, 1'b0);
    run_load("t4b", 32'h2, 1, 100, -1, 1'b0);
    run_load("t4c", 32'h40, 0, 100, -1, 1'b0);
    check("t4_writes", obs_wr_cnt, 0);
    run_load("t4d", 32'h3FC, 5, 100, -1, 1'b0);
    run_load("t4e", 32'h3FC, 4, 100, -1, 1'b0);
    check("t4_fit_writes", obs_wr_cnt, 4);

    // 5: reset after 3 of 8 bytes, then a clean reload
    bytes_q.delete();
    for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
    do_start(32'h100, 8, acc);
    send_bytes(3, -1, 100);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("t5_reset");
    exp_wr_q.delete();
    exp_word_q.delete();
    exp_done_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_done", bus.done, 0);
    run_load("t5_reload", 32'h100, 8, 80, -1, 1'b0);

    // 6: start pulsed mid-load is ignored
    run_load("t6", 32'h40, 8, 70, 2, 1'b0);

    // randomized loads, including out-of-range and misaligned starts
    for (int r = 0; r < 12; r++) begin
      int          len;
      logic [31:0] base;
      len = $urandom_range(1, 20);
      if ($urandom_range(0, 3) == 0) base = 32'($urandom_range(0, 1100));
      else base = 32'($urandom_range(0, (IMEM_SIZE - len) / 4) * 4);
      run_load("rnd", base, len, $urandom_range(30, 100), -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
